// File: rtl/ara_perf_pkg.sv
// Shared types and constants for the Ara vector performance monitor.
package ara_perf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } perf_state_e;

  localparam int unsigned RuntimeIdx   = 0;
  localparam int unsigned StateWidth   = 2;
  localparam int unsigned SnapCntWidth = 16;

endpackage

// File: rtl/ara_perf_counter.sv
// Single performance counter with synchronous clear, sticky overflow and
// selectable saturate/wrap behaviour at all-ones.
module ara_perf_counter #(
  parameter int unsigned CntWidth = 64,
  parameter bit          Saturate = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                clear_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                ovf_o
);

  logic at_max;

  // All-ones detect decides between increment and overflow handling
  assign at_max = &cnt_o;

  // Counter and sticky overflow; clear wins over a simultaneous increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (clear_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (en_i) begin
      if (at_max) begin
        ovf_o <= 1'b1;
        cnt_o <= Saturate ? cnt_o : '0;
      end else begin
        cnt_o <= cnt_o + CntWidth'(1);
      end
    end
  end

endmodule

// File: rtl/ara_perf_monitor.sv
// Vector performance monitor: runtime plus NrEvents event counters over a
// software-gated window, frozen into snapshot buffers when Ara goes idle
// after the last dispatched vector instruction.
module ara_perf_monitor
  import ara_perf_pkg::*;
#(
  parameter int unsigned NrEvents = 3,
  parameter int unsigned CntWidth = 64,
  parameter bit          Saturate = 1'b0,
  parameter int unsigned IdxWidth = $clog2(NrEvents + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cnt_en_i,
  input  logic                    vinsn_valid_i,
  input  logic                    ara_idle_i,
  input  logic [NrEvents-1:0]     event_i,
  input  logic                    clear_i,
  input  logic [IdxWidth-1:0]     rd_idx_i,
  output logic [CntWidth-1:0]     rd_data_o,
  output logic                    snapshot_valid_o,
  output logic [SnapCntWidth-1:0] snapshot_cnt_o,
  output logic [NrEvents:0]       overflow_o,
  output logic [StateWidth-1:0]   state_o
);

  localparam int unsigned NrCnt = NrEvents + 1;

  perf_state_e         state_q, state_d;
  logic                running;
  logic                snap_take;
  logic                pending_q;
  logic [NrCnt-1:0]    cnt_inc;
  logic [NrCnt-1:0]    ovf;
  logic [CntWidth-1:0] cnt    [NrCnt];
  logic [CntWidth-1:0] snap_q [NrCnt];

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state: window opens on a gated dispatch, drains until Ara idles
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vinsn_valid_i && cnt_en_i) state_d = RUN;
      RUN:     if (!cnt_en_i) state_d = ara_idle_i ? IDLE : DRAIN;
      DRAIN: begin
        if (cnt_en_i)        state_d = RUN;
        else if (ara_idle_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: per-counter increment enables and snapshot trigger
  always_comb begin
    running   = 1'b0;
    cnt_inc   = '0;
    snap_take = 1'b0;
    running             = (state_q != IDLE);
    cnt_inc[RuntimeIdx] = running;
    for (int k = 0; k < int'(NrEvents); k++) begin
      cnt_inc[k+1] = running & event_i[k];
    end
    snap_take = pending_q & ara_idle_i & ~vinsn_valid_i;
  end

  // Live counters: index 0 is runtime, index k is event channel k-1
  for (genvar i = 0; i < int'(NrCnt); i++) begin : g_cnt
    ara_perf_counter #(
      .CntWidth (CntWidth),
      .Saturate (Saturate)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (cnt_inc[i]),
      .clear_i (clear_i),
      .cnt_o   (cnt[i]),
      .ovf_o   (ovf[i])
    );
  end

  // Pending flag: armed by a dispatch, consumed by the snapshot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         pending_q <= 1'b0;
    else if (!pending_q && vinsn_valid_i) pending_q <= 1'b1;
    else if (snap_take)                  pending_q <= 1'b0;
  end

  // Snapshot buffers capture pre-increment, pre-clear live values
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrCnt); i++) snap_q[i] <= '0;
      snapshot_valid_o <= 1'b0;
      snapshot_cnt_o   <= '0;
    end else begin
      snapshot_valid_o <= snap_take;
      if (snap_take) begin
        for (int i = 0; i < int'(NrCnt); i++) snap_q[i] <= cnt[i];
        snapshot_cnt_o <= snapshot_cnt_o + SnapCntWidth'(1);
      end
    end
  end

  // Registered read port; out-of-range indices return zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       rd_data_o <= '0;
    else if (32'(rd_idx_i) < NrCnt)    rd_data_o <= snap_q[rd_idx_i];
    else                               rd_data_o <= '0;
  end

  assign overflow_o = ovf;
  assign state_o    = StateWidth'(state_q);

endmodule

// File: tb/tb_ara_perf_monitor.sv
// Bench for ara_perf_monitor: three instances (64-bit wrap, 8-bit saturate,
// 8-bit wrap) share one stimulus and are compared every cycle against a
// behavioural model, with literal pins on the directed scenarios.
module tb_ara_perf_monitor;

  localparam int ND = 3;
  localparam int NC = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cnt_en = 1'b0, vv = 1'b0, idle = 1'b1, clr = 1'b0;
  logic [3:0] ev = '0;
  logic [1:0] rd_a = '0;
  logic [2:0] rd_bc = '0;

  logic [63:0] rdo_a;  logic sv_a;  logic [15:0] scnt_a;  logic [3:0] ovf_a;  logic [1:0] st_a;
  logic [7:0]  rdo_b;  logic sv_b;  logic [15:0] scnt_b;  logic [4:0] ovf_b;  logic [1:0] st_b;
  logic [7:0]  rdo_c;  logic sv_c;  logic [15:0] scnt_c;  logic [4:0] ovf_c;  logic [1:0] st_c;

  always #5 clk = ~clk;

  ara_perf_monitor #(.NrEvents(3)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .cnt_en_i(cnt_en), .vinsn_valid_i(vv), .ara_idle_i(idle),
    .event_i(ev[2:0]), .clear_i(clr), .rd_idx_i(rd_a), .rd_data_o(rdo_a),
    .snapshot_valid_o(sv_a), .snapshot_cnt_o(scnt_a), .overflow_o(ovf_a), .state_o(st_a));

  ara_perf_monitor #(.NrEvents(4), .CntWidth(8), .Saturate(1'b1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .cnt_en_i(cnt_en), .vinsn_valid_i(vv), .ara_idle_i(idle),
    .event_i(ev), .clear_i(clr), .rd_idx_i(rd_bc), .rd_data_o(rdo_b),
    .snapshot_valid_o(sv_b), .snapshot_cnt_o(scnt_b), .overflow_o(ovf_b), .state_o(st_b));

  ara_perf_monitor #(.NrEvents(4), .CntWidth(8), .Saturate(1'b0)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .cnt_en_i(cnt_en), .vinsn_valid_i(vv), .ara_idle_i(idle),
    .event_i(ev), .clear_i(clr), .rd_idx_i(rd_bc), .rd_data_o(rdo_c),
    .snapshot_valid_o(sv_c), .snapshot_cnt_o(scnt_c), .overflow_o(ovf_c), .state_o(st_c));

  // ---------------- behavioural model ----------------
  int          n_ev [ND] = '{3, 4, 4};
  logic [63:0] mask [ND] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFF, 64'hFF};
  bit          sat  [ND] = '{1'b0, 1'b1, 1'b0};

  int          m_st   [ND];
  bit          m_pend [ND];
  bit          m_sv   [ND];
  logic [15:0] m_scnt [ND];
  logic [63:0] m_rd   [ND];
  logic [63:0] m_cnt  [ND][NC];
  logic [63:0] m_snap [ND][NC];
  bit          m_ovf  [ND][NC];

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin
      m_st[d] = 0; m_pend[d] = 0; m_sv[d] = 0; m_scnt[d] = '0; m_rd[d] = '0;
      for (int i = 0; i < NC; i++) begin
        m_cnt[d][i] = '0; m_snap[d][i] = '0; m_ovf[d][i] = 0;
      end
    end
  endfunction

  // One clock of the monitor, from the rules: read, snapshot, pending, count, state
  function automatic void model_step();
    for (int d = 0; d < ND; d++) begin
      int idx;
      bit active, snap, hit;
      idx    = (d == 0) ? int'(rd_a) : int'(rd_bc);
      active = (m_st[d] != 0);
      snap   = m_pend[d] && idle && !vv;
      if (idx <= n_ev[d]) m_rd[d] = m_snap[d][idx];
      else                m_rd[d] = '0;
      m_sv[d] = snap;
      if (snap) begin
        for (int i = 0; i <= n_ev[d]; i++) m_snap[d][i] = m_cnt[d][i];
        m_scnt[d] = m_scnt[d] + 16'd1;
      end
      if (!m_pend[d] && vv) m_pend[d] = 1;
      else if (snap)        m_pend[d] = 0;
      for (int i = 0; i <= n_ev[d]; i++) begin
        if (i == 0) hit = active;
        else        hit = active && ev[i-1];
        if (clr) begin
          m_cnt[d][i] = '0; m_ovf[d][i] = 0;
        end else if (hit) begin
          if (m_cnt[d][i] == mask[d]) begin
            m_ovf[d][i] = 1;
            m_cnt[d][i] = sat[d] ? mask[d] : 64'd0;
          end else begin
            m_cnt[d][i] = m_cnt[d][i] + 64'd1;
          end
        end
      end
      case (m_st[d])
        0: if (vv && cnt_en) m_st[d] = 1;
        1: if (!cnt_en) m_st[d] = idle ? 0 : 2;
        default: if (cnt_en) m_st[d] = 1; else if (idle) m_st[d] = 0;
      endcase
    end
  endfunction

  function automatic logic [63:0] m_out(int d, int sel);
    logic [63:0] v;
    v = '0;
    case (sel)
      0: v = m_rd[d];
      1: v = 64'(m_sv[d]);
      2: v = 64'(m_scnt[d]);
      3: for (int i = 0; i <= n_ev[d]; i++) v[i] = m_ovf[d][i];
      default: v = 64'(m_st[d]);
    endcase
    return v;
  endfunction

  function automatic logic [63:0] dut_out(int d, int sel);
    case (d)
      0: case (sel)
           0: return rdo_a; 1: return 64'(sv_a); 2: return 64'(scnt_a);
           3: return 64'(ovf_a); default: return 64'(st_a);
         endcase
      1: case (sel)
           0: return 64'(rdo_b); 1: return 64'(sv_b); 2: return 64'(scnt_b);
           3: return 64'(ovf_b); default: return 64'(st_b);
         endcase
      default: case (sel)
           0: return 64'(rdo_c); 1: return 64'(sv_c); 2: return 64'(scnt_c);
           3: return 64'(ovf_c); default: return 64'(st_c);
         endcase
    endcase
  endfunction

  function automatic string sig_name(int sel);
    case (sel)
      0: return "rd_data"; 1: return "snapshot_valid"; 2: return "snapshot_cnt";
      3: return "overflow"; default: return "state";
    endcase
  endfunction

  // ---------------- literal pins posted by the stimulus ----------------
  string       pin_name [8];
  int          pin_dut  [8];
  int          pin_sel  [8];
  logic [63:0] pin_exp  [8];
  int          pin_n = 0;
  int          pin_gen = 0;
  int          pin_seen = 0;
  bit          chk_on = 1'b0;

  task automatic pin_begin(); pin_n = 0; endtask
  task automatic pin(input string nm, input int d, input int sel, input logic [63:0] e);
    pin_name[pin_n] = nm; pin_dut[pin_n] = d; pin_sel[pin_n] = sel; pin_exp[pin_n] = e;
    pin_n++;
  endtask
  task automatic pin_end(); pin_gen++; endtask

  // ---------------- compare process ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d got=%0h expected=%0h at %0t", nm, d, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < ND; d++)
        for (int s = 0; s < 5; s++)
          check(sig_name(s), d, dut_out(d, s), m_out(d, s));
      if (pin_gen != pin_seen) begin
        for (int i = 0; i < pin_n; i++)
          check(pin_name[i], pin_dut[i], dut_out(pin_dut[i], pin_sel[i]), pin_exp[i]);
        pin_seen = pin_gen;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic ce, input logic v, input logic id, input logic [3:0] e, input logic c);
    cnt_en = ce; vv = v; idle = id; ev = e; clr = c;
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 19) == 0) cnt_en = ~cnt_en;
    if ($urandom_range(0, 5) == 0)  idle = ~idle;
    vv    = ($urandom_range(0, 7) == 0);
    ev    = 4'($urandom);
    clr   = ($urandom_range(0, 1499) == 0);
    rd_a  = 2'($urandom);
    rd_bc = 3'($urandom);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    chk_on = 1'b1;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      if (i == 4) begin
        pin_begin(); pin("rst_state", 0, 4, 0); pin("rst_scnt", 1, 2, 0); pin("rst_rd", 2, 0, 0); pin_end();
      end
      step();
    end
    drive(0, 0, 1, 4'h0, 0); rd_a = 0; rd_bc = 0;
    rst_n = 1'b1;
    step(); step();

    // Basic runtime window: 20 busy cycles
    drive(1, 1, 1, 4'h0, 0); step();
    repeat (20) begin drive(1, 0, 0, 4'h0, 0); step(); end
    pin_begin(); pin("snap_pulse", 0, 1, 1); pin("snap_cnt1", 0, 2, 1); pin("idle_again", 0, 4, 0); pin_end();
    drive(0, 0, 1, 4'h0, 0); step();
    pin_begin(); pin("runtime20", 0, 0, 20); pin("runtime20", 2, 0, 20); pin_end();
    step();

    // Drain: enable drops after 10 cycles while Ara stays busy 15 more
    drive(1, 1, 1, 4'h0, 1); step();
    repeat (10) begin drive(1, 0, 0, 4'h0, 0); step(); end
    pin_begin(); pin("drain_state", 0, 4, 2); pin_end();
    drive(0, 0, 0, 4'h0, 0); step();
    repeat (13) begin drive(0, 0, 0, 4'h0, 0); step(); end
    pin_begin(); pin("drain_last", 1, 4, 2); pin_end();
    step();
    pin_begin(); pin("drain_done", 0, 4, 0); pin("drain_pulse", 0, 1, 1); pin_end();
    drive(0, 0, 1, 4'h0, 0); step();
    pin_begin(); pin("runtime25", 0, 0, 25); pin("snap_cnt2", 0, 2, 2); pin_end();
    step();

    // Events: channel 1 high 3 cycles idle, 5 cycles running
    drive(0, 0, 1, 4'h0, 1); step();
    repeat (3) begin drive(0, 0, 1, 4'b0010, 0); step(); end
    drive(1, 1, 1, 4'h0, 0); step();
    for (int i = 0; i < 8; i++) begin drive(1, 0, 0, (i < 5) ? 4'b0010 : 4'b0000, 0); step(); end
    drive(0, 0, 1, 4'h0, 0); step();
    rd_a = 2; rd_bc = 2;
    pin_begin(); pin("ev1_cnt", 0, 0, 5); pin("ev1_cnt", 1, 0, 5); pin_end();
    step();
    rd_a = 1; rd_bc = 3;
    pin_begin(); pin("ev0_cnt", 0, 0, 0); pin("ev2_cnt", 1, 0, 0); pin_end();
    step();
    rd_a = 0; rd_bc = 0;
    pin_begin(); pin("runtime8", 0, 0, 8); pin_end();
    step();

    // Width: 300 running cycles on 8-bit saturating and wrapping counters
    drive(0, 0, 1, 4'h0, 1); step();
    drive(1, 1, 1, 4'h0, 0); step();
    repeat (300) begin drive(1, 0, 0, 4'h0, 0); step(); end
    pin_begin(); pin("ovf_sat", 1, 3, 1); pin("ovf_wrap", 2, 3, 1); pin("ovf_wide", 0, 3, 0); pin_end();
    drive(0, 0, 1, 4'h0, 0); step();
    pin_begin(); pin("rt_300", 0, 0, 300); pin("rt_sat", 1, 0, 255); pin("rt_wrap", 2, 0, 44); pin_end();
    step();

    // Clear colliding with a snapshot, then reset mid-run
    pin_begin(); pin("ovf_cleared", 1, 3, 0); pin("ovf_cleared", 2, 3, 0); pin_end();
    drive(1, 1, 1, 4'h0, 1); step();
    repeat (12) begin drive(1, 0, 0, 4'h0, 0); step(); end
    pin_begin(); pin("coll_pulse", 0, 1, 1); pin_end();
    drive(1, 0, 1, 4'h0, 1); step();
    pin_begin(); pin("coll_buf12", 0, 0, 12); pin("coll_buf12", 2, 0, 12); pin_end();
    drive(1, 0, 1, 4'h0, 0); step();
    drive(1, 1, 0, 4'h0, 0); step();
    drive(1, 0, 1, 4'h0, 0); step();
    pin_begin(); pin("post_clear2", 0, 0, 2); pin("post_clear2", 1, 0, 2); pin_end();
    step();
    drive(1, 0, 0, 4'h0, 0);
    @(posedge clk);
    model_step();
    #1 rst_n = 1'b0;
    model_reset();
    pin_begin(); pin("arst_state", 0, 4, 0); pin("arst_scnt", 0, 2, 0); pin("arst_rd", 0, 0, 0);
    pin("arst_state", 2, 4, 0); pin_end();
    @(negedge clk); #1;
    rand_inputs(); step();
    rand_inputs(); step();
    drive(0, 0, 1, 4'h0, 0);
    rst_n = 1'b1;
    step();

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
